// File: rtl/request_forwarder_pkg.sv
// rtl/request_forwarder_pkg.sv - shared types and sizing for the request forwarder
package request_forwarder_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE, ABORT} fwd_state_t;

  localparam int DEFAULT_NUMBER_OF_QUEUES = 4;
  localparam int DEFAULT_ID_WIDTH         = $clog2(DEFAULT_NUMBER_OF_QUEUES);

  function automatic int id_width(input int number_of_queues);
    return (number_of_queues > 1) ? $clog2(number_of_queues) : 1;
  endfunction

endpackage

// File: rtl/request_forwarder_if.sv
// rtl/request_forwarder_if.sv - valid/ready request channel toward the memory port
interface request_forwarder_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = request_forwarder_pkg::DEFAULT_ID_WIDTH
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [ID_WIDTH-1:0]   id;

  modport master (output valid, data, id, input ready);
  modport slave  (input valid, data, id, output ready);

endinterface

// File: rtl/forward_counter_bank.sv
// rtl/forward_counter_bank.sv - per-queue wrapping forwarded-request counters
module forward_counter_bank
  import request_forwarder_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32,
  localparam int ID_WIDTH        = id_width(NUMBER_OF_QUEUES)
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          inc,
  input  logic [ID_WIDTH-1:0]                           inc_index,
  input  logic                                          clear,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] counters
);

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      counters <= '0;
    end else if (inc) begin
      counters[inc_index] <= counters[inc_index] + REGISTER_SIZE'(1);
    end
  end

endmodule

// File: rtl/request_forwarder.sv
// rtl/request_forwarder.sv - pops the scheduled queue head and forwards it to the memory port
module request_forwarder
  import request_forwarder_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_WIDTH       = 64,
  parameter int REGISTER_SIZE    = 32,
  localparam int ID_WIDTH        = id_width(NUMBER_OF_QUEUES)
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           enable,
  input  logic [ID_WIDTH-1:0]                            id,
  input  logic [NUMBER_OF_QUEUES-1:0]                    empty,
  input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0]    head_data,
  output logic [NUMBER_OF_QUEUES-1:0]                    pop,
  request_forwarder_if.master                            m,
  output logic                                           consumed,
  output logic                                           busy,
  input  logic                                           counters_clear,
  input  logic                                           err_clear,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] forwarded,
  output logic                                           err_empty,
  output logic                                           err_overlap
);

  fwd_state_t            state;
  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [ID_WIDTH-1:0]   id_reg;
  logic                  handshake;
  logic                  empty_hit;
  logic                  overlap_hit;

  assign m.valid = valid_reg;
  assign m.data  = data_reg;
  assign m.id    = id_reg;

  assign handshake   = (state == SEND) && valid_reg && m.ready;
  assign empty_hit   = enable && (state == IDLE) && empty[id];
  assign overlap_hit = enable && (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      id_reg    <= '0;
      pop       <= '0;
      consumed  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pop      <= '0;
      consumed <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            busy <= 1'b1;
            if (empty[id]) begin
              state    <= ABORT;
              consumed <= 1'b1;
            end else begin
              state     <= SEND;
              valid_reg <= 1'b1;
              pop[id]   <= 1'b1;
              data_reg  <= head_data[id];
              id_reg    <= id;
            end
          end
        end
        SEND: begin
          if (handshake) begin
            state     <= DONE;
            valid_reg <= 1'b0;
            consumed  <= 1'b1;
          end
        end
        DONE, ABORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          valid_reg <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // A new error event beats a coincident clear so no event is ever lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_empty   <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      if (empty_hit)        err_empty <= 1'b1;
      else if (err_clear)   err_empty <= 1'b0;
      if (overlap_hit)      err_overlap <= 1'b1;
      else if (err_clear)   err_overlap <= 1'b0;
    end
  end

  forward_counter_bank #(
    .NUMBER_OF_QUEUES(NUMBER_OF_QUEUES),
    .REGISTER_SIZE   (REGISTER_SIZE)
  ) u_counters (
    .clock    (clock),
    .reset    (reset),
    .inc      (handshake),
    .inc_index(id_reg),
    .clear    (counters_clear),
    .counters (forwarded)
  );

endmodule

// File: tb/tb_request_forwarder.sv
// tb/tb_request_forwarder.sv - directed self-checking bench for request_forwarder
module tb_request_forwarder;

  localparam int NQ = 4;
  localparam int DW = 64;
  localparam int RS = 4;
  localparam int IW = 2;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   enable;
  logic [IW-1:0]          id;
  logic [NQ-1:0]          empty;
  logic [NQ-1:0][DW-1:0]  head_data;
  logic [NQ-1:0]          pop;
  logic                   consumed;
  logic                   busy;
  logic                   counters_clear;
  logic                   err_clear;
  logic [NQ-1:0][RS-1:0]  forwarded;
  logic                   err_empty;
  logic                   err_overlap;

  int checks = 0;
  int errors = 0;

  request_forwarder_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  request_forwarder #(
    .NUMBER_OF_QUEUES(NQ),
    .DATA_WIDTH      (DW),
    .REGISTER_SIZE   (RS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .id            (id),
    .empty         (empty),
    .head_data     (head_data),
    .pop           (pop),
    .m             (bus),
    .consumed      (consumed),
    .busy          (busy),
    .counters_clear(counters_clear),
    .err_clear     (err_clear),
    .forwarded     (forwarded),
    .err_empty     (err_empty),
    .err_overlap   (err_overlap)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; id = '0; empty = '1; head_data = '0;
    counters_clear = 1'b0; err_clear = 1'b0; bus.ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_pop", 64'(pop), 64'h0);
    check("rst_valid", 64'(bus.valid), 64'h0);
    check("rst_consumed", 64'(consumed), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_err_empty", 64'(err_empty), 64'h0);
    check("rst_err_overlap", 64'(err_overlap), 64'h0);
    check("rst_m_data", bus.data, 64'h0);
    check("rst_m_id", 64'(bus.id), 64'h0);
    check("rst_forwarded", 64'(forwarded), 64'h0);

    // Normal transfer on queue 1
    empty = 4'b1101;
    head_data[0] = 64'h1111_2222_3333_4444;
    head_data[1] = 64'hDEAD_BEEF;
    head_data[2] = 64'h5555_6666;
    head_data[3] = 64'h7777_8888;
    bus.ready = 1'b1;
    enable = 1'b1; id = 2'd1;
    tick();
    enable = 1'b0;
    check("norm_pop", 64'(pop), 64'h2);
    check("norm_valid", 64'(bus.valid), 64'h1);
    check("norm_data", bus.data, 64'hDEAD_BEEF);
    check("norm_id", 64'(bus.id), 64'h1);
    check("norm_busy1", 64'(busy), 64'h1);
    check("norm_cons1", 64'(consumed), 64'h0);
    tick();
    check("norm_cons2", 64'(consumed), 64'h1);
    check("norm_valid2", 64'(bus.valid), 64'h0);
    check("norm_pop2", 64'(pop), 64'h0);
    check("norm_busy2", 64'(busy), 64'h1);
    check("norm_fwd1", 64'(forwarded[1]), 64'h1);
    tick();
    check("norm_cons3", 64'(consumed), 64'h0);
    check("norm_busy3", 64'(busy), 64'h0);

    // Backpressure: ready low for 5 cycles
    head_data[1] = 64'hCAFE_F00D;
    bus.ready = 1'b0;
    enable = 1'b1; id = 2'd1;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(bus.valid), 64'h1);
      check("bp_data", bus.data, 64'hCAFE_F00D);
      check("bp_cons", 64'(consumed), 64'h0);
      check("bp_pop", 64'(pop), (i == 0) ? 64'h2 : 64'h0);
      if (i == 1) head_data[1] = 64'hBAD0_BAD0;
      tick();
    end
    check("bp_valid6", 64'(bus.valid), 64'h1);
    check("bp_data6", bus.data, 64'hCAFE_F00D);
    bus.ready = 1'b1;
    tick();
    check("bp_cons", 64'(consumed), 64'h1);
    check("bp_fwd1", 64'(forwarded[1]), 64'h2);
    tick();
    check("bp_cons_end", 64'(consumed), 64'h0);

    // Empty queue abort
    enable = 1'b1; id = 2'd2;
    tick();
    enable = 1'b0;
    check("emp_cons", 64'(consumed), 64'h1);
    check("emp_err", 64'(err_empty), 64'h1);
    check("emp_pop", 64'(pop), 64'h0);
    check("emp_valid", 64'(bus.valid), 64'h0);
    check("emp_busy", 64'(busy), 64'h1);
    tick();
    check("emp_cons2", 64'(consumed), 64'h0);
    check("emp_busy2", 64'(busy), 64'h0);
    check("emp_valid2", 64'(bus.valid), 64'h0);
    check("emp_fwd2", 64'(forwarded[2]), 64'h0);
    check("emp_fwd1", 64'(forwarded[1]), 64'h2);

    // Error event beats coincident clear, then clear alone works
    enable = 1'b1; id = 2'd2; err_clear = 1'b1;
    tick();
    enable = 1'b0;
    check("errpri_set", 64'(err_empty), 64'h1);
    tick();
    err_clear = 1'b0;
    check("errpri_clr", 64'(err_empty), 64'h0);

    // Overlap during SEND
    bus.ready = 1'b0;
    enable = 1'b1; id = 2'd1;
    tick();
    id = 2'd3;
    check("ovl_pop1", 64'(pop), 64'h2);
    tick();
    enable = 1'b0;
    check("ovl_err", 64'(err_overlap), 64'h1);
    check("ovl_pop2", 64'(pop), 64'h0);
    check("ovl_valid", 64'(bus.valid), 64'h1);
    check("ovl_id", 64'(bus.id), 64'h1);
    check("ovl_cons0", 64'(consumed), 64'h0);
    bus.ready = 1'b1;
    tick();
    check("ovl_cons", 64'(consumed), 64'h1);
    tick();
    check("ovl_cons_end", 64'(consumed), 64'h0);
    check("ovl_fwd1", 64'(forwarded[1]), 64'h3);
    check("ovl_fwd3", 64'(forwarded[3]), 64'h0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("ovl_clr", 64'(err_overlap), 64'h0);

    // Wrap of a 4-bit counter after 16 transfers on queue 0
    empty = 4'b1100;
    for (int i = 0; i < 16; i++) begin
      enable = 1'b1; id = 2'd0;
      tick();
      enable = 1'b0;
      tick();
      tick();
      if (i == 14) check("wrap_15", 64'(forwarded[0]), 64'hF);
    end
    check("wrap_0", 64'(forwarded[0]), 64'h0);
    check("wrap_fwd1", 64'(forwarded[1]), 64'h3);

    // Clear coincident with increment
    enable = 1'b1; id = 2'd0;
    tick();
    enable = 1'b0;
    counters_clear = 1'b1;
    tick();
    counters_clear = 1'b0;
    check("clr_cons", 64'(consumed), 64'h1);
    check("clr_fwd0", 64'(forwarded[0]), 64'h0);
    check("clr_fwd1", 64'(forwarded[1]), 64'h0);
    tick();

    // Reset mid-transfer, then a fresh transfer
    bus.ready = 1'b0;
    enable = 1'b1; id = 2'd1;
    tick();
    enable = 1'b0;
    check("rmt_valid_pre", 64'(bus.valid), 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmt_valid", 64'(bus.valid), 64'h0);
    check("rmt_busy", 64'(busy), 64'h0);
    check("rmt_cons", 64'(consumed), 64'h0);
    check("rmt_pop", 64'(pop), 64'h0);
    bus.ready = 1'b1;
    enable = 1'b1; id = 2'd1;
    tick();
    enable = 1'b0;
    check("rmt_valid2", 64'(bus.valid), 64'h1);
    tick();
    check("rmt_cons2", 64'(consumed), 64'h1);
    check("rmt_fwd1", 64'(forwarded[1]), 64'h1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
